// File: rtl/alu_wb_stage.sv
// ALU write-back stage: a 2-entry FIFO of ALU results feeding the register file.
// Popping the head entry commits it, optionally updating the flag register.
module alu_wb_stage #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] aout,
   input  logic [3:0]   fout,
   input  logic [2:0]   rd,
   input  logic         wflag,
   input  logic         flush,
   output logic         wb_valid,
   input  logic         wb_ready,
   output logic [W-1:0] wb_data,
   output logic [2:0]   wb_addr,
   output logic [3:0]   flags,
   output logic [15:0]  commit_cnt
);

   logic [1:0]   count_r;
   logic [1:0]   count_nxt_s;
   logic         wr_ptr_r;
   logic         wr_ptr_nxt_s;
   logic         rd_ptr_r;
   logic         rd_ptr_nxt_s;
   logic [W-1:0] data_r [2];
   logic [3:0]   fl_r   [2];
   logic [2:0]   addr_r [2];
   logic [1:0]   wf_r;
   logic [3:0]   flags_r;
   logic [15:0]  cnt_r;
   logic         push_s;
   logic         pop_s;

   // Handshake qualification; flush suppresses both transfers.
   always_comb begin
      push_s = 1'b0;
      pop_s  = 1'b0;
      if (flush) begin
         push_s = 1'b0;
         pop_s  = 1'b0;
      end else begin
         push_s = in_valid && in_ready;
         pop_s  = wb_valid && wb_ready;
      end
   end

   // Next occupancy and pointer values.
   always_comb begin
      count_nxt_s  = count_r;
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      if (flush) begin
         count_nxt_s  = 2'd0;
         wr_ptr_nxt_s = 1'b0;
         rd_ptr_nxt_s = 1'b0;
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
         endcase
         if (push_s) begin
            wr_ptr_nxt_s = ~wr_ptr_r;
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_nxt_s = ~rd_ptr_r;
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
      end
   end

   // Occupancy and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r  <= 2'd0;
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
      end else begin
         count_r  <= count_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
      end
   end

   // FIFO storage; cleared on reset so the write-back bus reads zero afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r[0] <= {W{1'b0}};
         data_r[1] <= {W{1'b0}};
         fl_r[0]   <= 4'b0000;
         fl_r[1]   <= 4'b0000;
         addr_r[0] <= 3'd0;
         addr_r[1] <= 3'd0;
         wf_r      <= 2'b00;
      end else if (push_s) begin
         data_r[wr_ptr_r] <= aout;
         fl_r[wr_ptr_r]   <= fout;
         addr_r[wr_ptr_r] <= rd;
         wf_r[wr_ptr_r]   <= wflag;
      end else begin
         wf_r <= wf_r;
      end
   end

   // Commit side: flag register and commit counter update only on a pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r <= 4'b0000;
         cnt_r   <= 16'd0;
      end else if (pop_s) begin
         cnt_r <= cnt_r + 16'd1;
         if (wf_r[rd_ptr_r]) begin
            flags_r <= fl_r[rd_ptr_r];
         end else begin
            flags_r <= flags_r;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Outputs are taken straight from registered state.
   always_comb begin
      in_ready   = (count_r != 2'd2);
      wb_valid   = (count_r != 2'd0);
      wb_data    = data_r[rd_ptr_r];
      wb_addr    = addr_r[rd_ptr_r];
      flags      = flags_r;
      commit_cnt = cnt_r;
   end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed vector table, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_alu_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] aout;
   logic [3:0]  fout;
   logic [2:0]  rd;
   logic        wflag;
   logic        flush;
   logic        wb_valid;
   logic        wb_ready;
   logic [15:0] wb_data;
   logic [2:0]  wb_addr;
   logic [3:0]  flags;
   logic [15:0] commit_cnt;

   int tests = 0;
   int fails = 0;

   alu_wb_stage #(.W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .aout(aout), .fout(fout), .rd(rd), .wflag(wflag), .flush(flush),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_addr(wb_addr), .flags(flags), .commit_cnt(commit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [15:0] a;
      logic [3:0]  f;
      logic [2:0]  r;
      logic        wf;
      logic        fl;
      logic        wbr;
      logic        ev;
      logic        cd;
      logic [15:0] ed;
      logic [2:0]  ea;
      logic        eir;
      logic [3:0]  efl;
      logic [15:0] ecnt;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  f;
      logic [2:0]  r;
      logic        wf;
   } ent_t;

   vec_t tbl[14];

   ent_t        mq[$];
   logic [3:0]  m_flags;
   logic [15:0] m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [15:0] a, input logic [3:0] f,
                        input logic [2:0] r, input logic wf, input logic fl, input logic wbr);
      in_valid = iv; aout = a; fout = f; rd = r; wflag = wf; flush = fl; wb_ready = wbr;
   endtask

   task automatic do_reset();
      drive(1'b0, 16'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
      chk("rst_wb_addr", {29'd0, wb_addr}, 32'd0);
      chk("rst_flags", {28'd0, flags}, 32'd0);
      chk("rst_cnt", {16'd0, commit_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mq.delete();
      m_flags = 4'b0000;
      m_cnt   = 16'd0;
   endtask

   // One randomized cycle checked against the reference model.
   task automatic rand_cycle();
      logic iv, fl, wbr, wf, exp_ready, do_push, do_pop;
      logic [15:0] a;
      logic [3:0] f;
      logic [2:0] r;
      ent_t e;
      iv  = ($urandom_range(0, 9) < 6);
      wbr = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 49) == 0);
      wf  = $urandom_range(0, 1) == 1;
      a   = 16'($urandom);
      f   = 4'($urandom);
      r   = 3'($urandom);
      drive(iv, a, f, r, wf, fl, wbr);
      #1;
      exp_ready = (mq.size() < 2);
      chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      chk("rnd_wb_valid_pre", {31'd0, wb_valid}, {31'd0, (mq.size() != 0)});
      do_push = iv && exp_ready && !fl;
      do_pop  = (mq.size() != 0) && wbr && !fl;
      @(posedge clk);
      if (fl) begin
         mq.delete();
      end else begin
         if (do_pop) begin
            e = mq.pop_front();
            m_cnt = m_cnt + 16'd1;
            if (e.wf) m_flags = e.f;
         end
         if (do_push) mq.push_back('{a, f, r, wf});
      end
      #1;
      chk("rnd_wb_valid", {31'd0, wb_valid}, {31'd0, (mq.size() != 0)});
      chk("rnd_flags", {28'd0, flags}, {28'd0, m_flags});
      chk("rnd_cnt", {16'd0, commit_cnt}, {16'd0, m_cnt});
      if (mq.size() != 0) begin
         chk("rnd_wb_data", {16'd0, wb_data}, {16'd0, mq[0].d});
         chk("rnd_wb_addr", {29'd0, wb_addr}, {29'd0, mq[0].r});
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 16'd13,  4'b0000, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd13,  3'd3, 1'b1, 4'b0000, 16'd0};
      tbl[1]  = '{1'b0, 16'd0,   4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,   3'd0, 1'b1, 4'b0000, 16'd1};
      tbl[2]  = '{1'b1, 16'd30,  4'b0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd30,  3'd1, 1'b1, 4'b0000, 16'd1};
      tbl[3]  = '{1'b1, 16'd100, 4'b0000, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd30,  3'd1, 1'b0, 4'b0000, 16'd1};
      tbl[4]  = '{1'b1, 16'd555, 4'b1111, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd30,  3'd1, 1'b0, 4'b0000, 16'd1};
      tbl[5]  = '{1'b0, 16'd0,   4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd100, 3'd2, 1'b1, 4'b0000, 16'd2};
      tbl[6]  = '{1'b0, 16'd0,   4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,   3'd0, 1'b1, 4'b0000, 16'd3};
      tbl[7]  = '{1'b1, 16'd0,   4'b0110, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0,   3'd4, 1'b1, 4'b0000, 16'd3};
      tbl[8]  = '{1'b1, 16'd1,   4'b0000, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1,   3'd5, 1'b1, 4'b0110, 16'd4};
      tbl[9]  = '{1'b0, 16'd0,   4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,   3'd0, 1'b1, 4'b0110, 16'd5};
      tbl[10] = '{1'b1, 16'd11,  4'b1111, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd11,  3'd1, 1'b1, 4'b0110, 16'd5};
      tbl[11] = '{1'b1, 16'd12,  4'b1111, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd11,  3'd1, 1'b0, 4'b0110, 16'd5};
      tbl[12] = '{1'b1, 16'd13,  4'b1111, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,   3'd0, 1'b1, 4'b0110, 16'd5};
      tbl[13] = '{1'b0, 16'd0,   4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,   3'd0, 1'b1, 4'b0110, 16'd5};

      do_reset();

      // Directed table: single pass, backpressure, flag commits, flush.
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].iv, tbl[i].a, tbl[i].f, tbl[i].r, tbl[i].wf, tbl[i].fl, tbl[i].wbr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, {31'd0, tbl[i].ev});
         chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].eir});
         chk($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, tbl[i].efl});
         chk($sformatf("v%0d_cnt", i), {16'd0, commit_cnt}, {16'd0, tbl[i].ecnt});
         if (tbl[i].cd) begin
            chk($sformatf("v%0d_wb_data", i), {16'd0, wb_data}, {16'd0, tbl[i].ed});
            chk($sformatf("v%0d_wb_addr", i), {29'd0, wb_addr}, {29'd0, tbl[i].ea});
         end
      end

      // Simultaneous push/pop at count=1 for 8 cycles.
      drive(1'b1, 16'd1, 4'd0, 3'd1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      for (int i = 2; i <= 9; i++) begin
         drive(1'b1, 16'(i), 4'd0, 3'(i), 1'b0, 1'b0, 1'b1);
         #1;
         chk("pp_head", {16'd0, wb_data}, i - 1);
         chk("pp_in_ready", {31'd0, in_ready}, 32'd1);
         @(posedge clk);
         #1;
         chk("pp_wb_valid", {31'd0, wb_valid}, 32'd1);
         chk("pp_next_head", {16'd0, wb_data}, i);
      end
      chk("pp_cnt", {16'd0, commit_cnt}, 32'd13);

      // Reset asserted mid-operation with a full FIFO.
      drive(1'b0, 16'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b1, 16'd77, 4'd0, 3'd6, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b1, 16'd88, 4'd0, 3'd7, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_wb_data", {16'd0, wb_data}, 32'd0);
      chk("arst_cnt", {16'd0, commit_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 16'd42, 4'd0, 3'd2, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("post_rst_push_valid", {31'd0, wb_valid}, 32'd1);
      chk("post_rst_push_data", {16'd0, wb_data}, 32'd42);
      chk("post_rst_push_addr", {29'd0, wb_addr}, 32'd2);

      // Randomized traffic against the queue model.
      do_reset();
      for (int i = 0; i < 3000; i++) rand_cycle();

      // Commit counter wrap.
      do_reset();
      drive(1'b1, 16'd5, 4'd0, 3'd1, 1'b0, 1'b0, 1'b1);
      repeat (65536) @(posedge clk);
      #1;
      chk("cnt_ffff", {16'd0, commit_cnt}, 32'h0000FFFF);
      @(posedge clk);
      #1;
      chk("cnt_wrap", {16'd0, commit_cnt}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL expose parameter W, default 16, ALU result/data width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  ALU result present this cycle.
REQ-005 SHALL have port in_ready  output  1  stage can accept a result.
REQ-006 SHALL have port aout  input  W  ALU result.
REQ-007 SHALL have port fout  input  4  ALU flags {S,Z,C,V}, bit3..bit0.
REQ-008 SHALL have port rd  input  3  destination register index.
REQ-009 SHALL have port wflag  input  1  result updates flag register on commit.
REQ-010 SHALL have port flush  input  1  synchronous discard of all pending entries.
REQ-011 SHALL have port wb_valid  output  1  write-back entry available.
REQ-012 SHALL have port wb_ready  input  1  register file accepts write-back.
REQ-013 SHALL have port wb_data  output  W  head entry result.
REQ-014 SHALL have port wb_addr  output  3  head entry destination.
REQ-015 SHALL have port flags  output  4  committed {S,Z,C,V}.
REQ-016 SHALL have port commit_cnt  output  16  number of committed entries.

Function
REQ-017 SHALL buffer entries {aout,fout,rd,wflag} in a 2-entry FIFO with 2-bit occupancy count (0..2).
REQ-018 SHALL drive in_ready = (count != 2), combinational from registered count only, never from in_valid or wb_ready.
REQ-019 SHALL push on clock edge when in_valid && in_ready && !flush; push latency 1 cycle (entry visible on wb_* the next cycle when FIFO was empty).
REQ-020 SHALL drive wb_valid = (count != 0); wb_data/wb_addr SHALL come from head entry register, no combinational path from aout.
REQ-021 SHALL pop on clock edge when wb_valid && wb_ready && !flush; popping is the commit point.
REQ-022 SHALL, on commit of an entry with wflag=1, load flags with that entry's fout; wflag=0 SHALL leave flags unchanged.
REQ-023 SHALL increment commit_cnt by 1 per commit, wrapping 16'hFFFF -> 0.
REQ-024 SHALL handle simultaneous push and pop: count unchanged, head advances, new entry enters tail; with count=1 new entry becomes head next cycle.
REQ-025 SHALL hold wb_data/wb_addr stable while wb_valid && !wb_ready.
REQ-026 SHALL preserve FIFO order; no entry lost or duplicated; write pointer and read pointer 1-bit each, wrapping 1 -> 0.
REQ-027 SHALL, on flush, set count=0 and both pointers to 0 next edge; flush overrides same-cycle push and pop; flags and commit_cnt unchanged; no commit occurs that cycle.
REQ-028 SHALL ignore aout/fout/rd/wflag when in_valid=0 or in_ready=0.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force count=0, pointers=0, flags=4'b0000, commit_cnt=0, hence wb_valid=0, in_ready=1.
REQ-030 SHALL zero FIFO storage on reset so wb_data=0 and wb_addr=0 after reset.
REQ-031 SHALL discard in-flight entries on reset mid-operation without committing them; first edge after rst_n rises SHALL accept a push.

Verification
REQ-032 Single pass: aout=16'd13 (5+8), fout=4'b0000, rd=3, wflag=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=13, wb_addr=3; following cycle flags=0000, commit_cnt=1, wb_valid=0.
REQ-033 Backpressure: wb_ready=0, push 16'd30 rd=1 then 16'd100 rd=2 -> count=2, in_ready=0, third push ignored; release wb_ready -> writes 30 then 100 in order, commit_cnt +2.
REQ-034 Flags: commit aout=16'd0 fout=4'b0110 wflag=1, then aout=16'd1 fout=4'b0000 wflag=0 -> flags=0110 after both commits.
REQ-035 Simultaneous push/pop at count=1 for 8 consecutive cycles with values 1..8 -> wb_data sequence 1..8, count stays 1, in_ready stays 1.
REQ-036 Flush with count=2 and in_valid=1 same cycle -> count=0, wb_valid=0, flags and commit_cnt unchanged; reset asserted with count=2 -> all outputs at reset values immediately.
REQ-037 Counter wrap: preload via 65535 commits -> commit_cnt=16'hFFFF; one more commit -> 16'h0000.
